// File: rtl/endmember_store_if.sv
// Engine/loader-facing bus of the endmember store: load stream, status and the dual read port.
interface endmember_store_if #(
    parameter int unsigned I_WIDTH          = 16,
    parameter int unsigned SPECTRAL_BANDS   = 103,
    parameter int unsigned TOTAL_ENDMEMBERS = 20
);
    localparam int unsigned BW = $clog2(SPECTRAL_BANDS);
    localparam int unsigned EW = $clog2(TOTAL_ENDMEMBERS);
    localparam int unsigned CW = EW + 1;

    logic               load_start;
    logic [CW-1:0]      load_count;
    logic [I_WIDTH-1:0] wr_data;
    logic               wr_valid;
    logic               wr_ready;
    logic               load_done;
    logic [CW-1:0]      num_loaded;
    logic [BW-1:0]      U_row;
    logic [EW-1:0]      U_col;
    logic [EW-1:0]      new_vectorT_row;
    logic [BW-1:0]      new_vectorT_col;
    logic               addr_valid_in;
    logic [I_WIDTH-1:0] U_out;
    logic [I_WIDTH-1:0] new_vectorT_out;
    logic               valid_out;
    logic               err;

    modport master (
        output load_start, load_count, wr_data, wr_valid,
        output U_row, U_col, new_vectorT_row, new_vectorT_col, addr_valid_in,
        input  wr_ready, load_done, num_loaded,
        input  U_out, new_vectorT_out, valid_out, err
    );

    modport slave (
        input  load_start, load_count, wr_data, wr_valid,
        input  U_row, U_col, new_vectorT_row, new_vectorT_col, addr_valid_in,
        output wr_ready, load_done, num_loaded,
        output U_out, new_vectorT_out, valid_out, err
    );
endinterface

// File: rtl/endmember_store.sv
// Endmember matrix store: streamed band-major load, two independent fixed-latency read ports
// (U[band][em] and its transpose view) with per-port legality checking and a sticky error flag.
module endmember_store #(
    parameter int unsigned I_WIDTH          = 16,
    parameter int unsigned SPECTRAL_BANDS   = 103,
    parameter int unsigned TOTAL_ENDMEMBERS = 20,
    parameter int unsigned READ_LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    endmember_store_if.slave  bus
);
    localparam int unsigned BW    = $clog2(SPECTRAL_BANDS);
    localparam int unsigned EW    = $clog2(TOTAL_ENDMEMBERS);
    localparam int unsigned CW    = EW + 1;
    localparam int unsigned DEPTH = SPECTRAL_BANDS * TOTAL_ENDMEMBERS;
    localparam int unsigned AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_wr_ready;
    logic               r_load_done;
    logic [CW-1:0]      r_num_loaded;
    logic               r_err;
    logic [CW-1:0]      r_count;
    logic [BW-1:0]      r_band_ptr;
    logic [EW-1:0]      r_em_ptr;
    logic [I_WIDTH-1:0] r_mem [DEPTH];

    logic               r_pv  [READ_LATENCY];
    logic [I_WIDTH-1:0] r_pu  [READ_LATENCY];
    logic [I_WIDTH-1:0] r_pvt [READ_LATENCY];

    logic               w_u_ok;
    logic               w_v_ok;
    logic               w_cnt_ok;
    logic               w_wr_en;
    logic [AW-1:0]      w_u_idx;
    logic [AW-1:0]      w_v_idx;
    logic [AW-1:0]      w_wr_idx;

    // Legality is judged on the issue-cycle state; illegal ports read address 0 and are zeroed.
    assign w_u_ok = (r_state == S_READY)
                 && ({1'b0, bus.U_row} < (BW+1)'(SPECTRAL_BANDS))
                 && ({1'b0, bus.U_col} < r_num_loaded);
    assign w_v_ok = (r_state == S_READY)
                 && ({1'b0, bus.new_vectorT_col} < (BW+1)'(SPECTRAL_BANDS))
                 && ({1'b0, bus.new_vectorT_row} < r_num_loaded);
    assign w_u_idx  = w_u_ok ? AW'(bus.U_col) * AW'(SPECTRAL_BANDS) + AW'(bus.U_row) : '0;
    assign w_v_idx  = w_v_ok ? AW'(bus.new_vectorT_row) * AW'(SPECTRAL_BANDS)
                               + AW'(bus.new_vectorT_col) : '0;
    assign w_cnt_ok = (bus.load_count >= CW'(1)) && (bus.load_count <= CW'(TOTAL_ENDMEMBERS));
    assign w_wr_en  = (r_state == S_LOAD) && bus.wr_valid;
    assign w_wr_idx = AW'(r_em_ptr) * AW'(SPECTRAL_BANDS) + AW'(r_band_ptr);

    // Control FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_ready   <= 1'b0;
            r_load_done  <= 1'b0;
            r_num_loaded <= '0;
            r_err        <= 1'b0;
            r_count      <= '0;
            r_band_ptr   <= '0;
            r_em_ptr     <= '0;
        end else begin
            r_load_done <= 1'b0;
            case (r_state)
                S_IDLE, S_READY: begin
                    if (bus.load_start) begin
                        if (w_cnt_ok) begin
                            r_state      <= S_LOAD;
                            r_wr_ready   <= 1'b1;
                            r_count      <= bus.load_count;
                            r_band_ptr   <= '0;
                            r_em_ptr     <= '0;
                            r_num_loaded <= '0;
                            r_err        <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (bus.wr_valid) begin
                        if (r_band_ptr == BW'(SPECTRAL_BANDS - 1)) begin
                            r_band_ptr   <= '0;
                            r_em_ptr     <= r_em_ptr + EW'(1);
                            r_num_loaded <= CW'(r_em_ptr) + CW'(1);
                            if (CW'(r_em_ptr) == r_count - CW'(1)) begin
                                r_state     <= S_READY;
                                r_wr_ready  <= 1'b0;
                                r_load_done <= 1'b1;
                            end
                        end else begin
                            r_band_ptr <= r_band_ptr + BW'(1);
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_wr_ready <= 1'b0;
                end
            endcase
            // An illegal read in the same cycle as a legal load_start still leaves err set.
            if (bus.addr_valid_in && !(w_u_ok && w_v_ok))
                r_err <= 1'b1;
        end
    end

    // Storage write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[w_wr_idx] <= bus.wr_data;
    end

    // Read pipeline: stage 0 samples storage, later stages delay to READ_LATENCY.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < READ_LATENCY; k++) begin
                r_pv[k]  <= 1'b0;
                r_pu[k]  <= '0;
                r_pvt[k] <= '0;
            end
        end else begin
            r_pv[0]  <= bus.addr_valid_in;
            r_pu[0]  <= (bus.addr_valid_in && w_u_ok) ? r_mem[w_u_idx] : '0;
            r_pvt[0] <= (bus.addr_valid_in && w_v_ok) ? r_mem[w_v_idx] : '0;
            for (int unsigned k = 1; k < READ_LATENCY; k++) begin
                r_pv[k]  <= r_pv[k-1];
                r_pu[k]  <= r_pu[k-1];
                r_pvt[k] <= r_pvt[k-1];
            end
        end
    end

    assign bus.wr_ready        = r_wr_ready;
    assign bus.load_done       = r_load_done;
    assign bus.num_loaded      = r_num_loaded;
    assign bus.err             = r_err;
    assign bus.valid_out       = r_pv[READ_LATENCY-1];
    assign bus.U_out           = r_pu[READ_LATENCY-1];
    assign bus.new_vectorT_out = r_pvt[READ_LATENCY-1];
endmodule

// File: tb/tb_endmember_store.sv
// Directed bench for endmember_store: loads, reads, streaming, error cases and resets.
module tb_endmember_store;
    localparam int unsigned SB = 103;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    endmember_store_if bus ();
    endmember_store dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp     = 0;
    int n_bad     = 0;
    int ld_pulses = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.load_done) ld_pulses++;
    endtask

    task automatic rd(input string tag, input int ur, input int uc, input int vr, input int vc,
                      input logic [31:0] eu, input logic [31:0] ev, input logic [31:0] eerr);
        bus.U_row           = 7'(ur);
        bus.U_col           = 5'(uc);
        bus.new_vectorT_row = 5'(vr);
        bus.new_vectorT_col = 7'(vc);
        bus.addr_valid_in   = 1'b1;
        tick();
        bus.addr_valid_in = 1'b0;
        chk({tag, "_early"}, 32'(bus.valid_out), 0);
        tick();
        chk({tag, "_vld"}, 32'(bus.valid_out), 1);
        chk({tag, "_u"},   32'(bus.U_out), eu);
        chk({tag, "_vt"},  32'(bus.new_vectorT_out), ev);
        chk({tag, "_err"}, 32'(bus.err), eerr);
    endtask

    task automatic stream_samples(input int cnt, input int salt, input int gap);
        for (int e = 0; e < cnt; e++) begin
            for (int b = 0; b < int'(SB); b++) begin
                bus.wr_data  = 16'(salt + e * 256 + b);
                bus.wr_valid = 1'b1;
                tick();
                bus.wr_valid = 1'b0;
                bus.wr_data  = 16'hDEAD;
                if (e == cnt - 1 && b == int'(SB) - 1)
                    chk("load_done_last", 32'(bus.load_done), 1);
                repeat (gap) tick();
            end
        end
    endtask

    task automatic do_load(input int cnt, input int salt, input int gap);
        ld_pulses       = 0;
        bus.load_start  = 1'b1;
        bus.load_count  = 6'(cnt);
        tick();
        bus.load_start = 1'b0;
        chk("ld_wr_ready", 32'(bus.wr_ready), 1);
        chk("ld_err_clr",  32'(bus.err), 0);
        chk("ld_num_zero", 32'(bus.num_loaded), 0);
        stream_samples(cnt, salt, gap);
        tick();
        chk("ld_pulses",   32'(ld_pulses), 1);
        chk("ld_rdy_low",  32'(bus.wr_ready), 0);
        chk("ld_num",      32'(bus.num_loaded), 32'(cnt));
    endtask

    initial begin
        bus.load_start      = 1'b0;
        bus.load_count      = '0;
        bus.wr_data         = '0;
        bus.wr_valid        = 1'b0;
        bus.U_row           = '0;
        bus.U_col           = '0;
        bus.new_vectorT_row = '0;
        bus.new_vectorT_col = '0;
        bus.addr_valid_in   = 1'b0;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_wr_ready", 32'(bus.wr_ready), 0);
        chk("rst_ld_done",  32'(bus.load_done), 0);
        chk("rst_valid",    32'(bus.valid_out), 0);
        chk("rst_err",      32'(bus.err), 0);
        chk("rst_num",      32'(bus.num_loaded), 0);
        chk("rst_u",        32'(bus.U_out), 0);
        chk("rst_vt",       32'(bus.new_vectorT_out), 0);

        rd("idle_rd", 0, 0, 0, 0, 0, 0, 1);

        do_load(20, 0, 0);
        rd("main_rd", 5, 3, 7, 100, 32'h0305, 32'h0764, 0);

        // Back-to-back stream: response for request c-1 is visible after the tick of iteration c.
        bus.U_col           = '0;
        bus.new_vectorT_row = 5'(19);
        for (int c = 0; c <= int'(SB); c++) begin
            if (c < int'(SB)) begin
                bus.addr_valid_in   = 1'b1;
                bus.U_row           = 7'(c);
                bus.new_vectorT_col = 7'(c);
            end else begin
                bus.addr_valid_in = 1'b0;
            end
            tick();
            if (c >= 1) begin
                chk("strm_vld", 32'(bus.valid_out), 1);
                chk("strm_u",   32'(bus.U_out), 32'(c - 1));
                chk("strm_vt",  32'(bus.new_vectorT_out), 32'(32'h1300 + c - 1));
            end
        end
        tick();
        chk("strm_end", 32'(bus.valid_out), 0);

        rd("edge_rd", 102, 19, 0, 0, 32'h1366, 0, 0);

        bus.load_start = 1'b1;
        bus.load_count = 6'(0);
        tick();
        bus.load_start = 1'b0;
        chk("cnt0_wr_ready", 32'(bus.wr_ready), 0);
        chk("cnt0_err",      32'(bus.err), 1);
        chk("cnt0_num",      32'(bus.num_loaded), 20);
        bus.load_start = 1'b1;
        bus.load_count = 6'(21);
        tick();
        bus.load_start = 1'b0;
        chk("cnt21_wr_ready", 32'(bus.wr_ready), 0);
        chk("cnt21_err",      32'(bus.err), 1);
        rd("post_bad_rd", 1, 1, 2, 2, 32'h0101, 32'h0202, 1);

        do_load(2, 32'h4000, 2);
        rd("col_oob_rd", 4, 2, 1, 50, 0, 32'h4132, 1);
        rd("gap_rd", 102, 1, 0, 0, 32'h4166, 32'h4000, 1);

        // Read issued alongside load_start is served from the old contents.
        ld_pulses           = 0;
        bus.load_start      = 1'b1;
        bus.load_count      = 6'(1);
        bus.U_row           = 7'(3);
        bus.U_col           = 5'(1);
        bus.new_vectorT_row = 5'(0);
        bus.new_vectorT_col = 7'(7);
        bus.addr_valid_in   = 1'b1;
        tick();
        bus.load_start    = 1'b0;
        bus.addr_valid_in = 1'b0;
        chk("ovl_wr_ready", 32'(bus.wr_ready), 1);
        chk("ovl_err",      32'(bus.err), 0);
        chk("ovl_early",    32'(bus.valid_out), 0);
        tick();
        chk("ovl_vld", 32'(bus.valid_out), 1);
        chk("ovl_u",   32'(bus.U_out), 32'h4103);
        chk("ovl_vt",  32'(bus.new_vectorT_out), 32'h4007);
        stream_samples(1, 32'h3000, 0);
        tick();
        chk("ovl_pulses", 32'(ld_pulses), 1);
        chk("ovl_num",    32'(bus.num_loaded), 1);
        rd("ovl_rd", 50, 0, 0, 60, 32'h3032, 32'h303C, 0);

        // Reset one cycle after a read issue drops it.
        bus.U_row           = '0;
        bus.U_col           = '0;
        bus.new_vectorT_row = '0;
        bus.new_vectorT_col = '0;
        bus.addr_valid_in   = 1'b1;
        tick();
        bus.addr_valid_in = 1'b0;
        rst = 1'b1;
        tick();
        chk("rrst_vld0", 32'(bus.valid_out), 0);
        tick();
        chk("rrst_vld1", 32'(bus.valid_out), 0);
        rst = 1'b0;
        tick();
        chk("rrst_vld2",  32'(bus.valid_out), 0);
        chk("rrst_num",   32'(bus.num_loaded), 0);
        chk("rrst_wrrdy", 32'(bus.wr_ready), 0);
        chk("rrst_err",   32'(bus.err), 0);

        // Reads during LOAD are illegal; reset mid-load returns to IDLE.
        bus.load_start = 1'b1;
        bus.load_count = 6'(5);
        tick();
        bus.load_start = 1'b0;
        bus.wr_data    = 16'h5555;
        bus.wr_valid   = 1'b1;
        repeat (2) tick();
        bus.wr_valid = 1'b0;
        rd("load_rd", 0, 0, 0, 0, 0, 0, 1);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("lrst_wrrdy", 32'(bus.wr_ready), 0);
        chk("lrst_num",   32'(bus.num_loaded), 0);
        chk("lrst_err",   32'(bus.err), 0);
        bus.wr_data  = 16'hBEEF;
        bus.wr_valid = 1'b1;
        repeat (3) tick();
        bus.wr_valid = 1'b0;
        chk("idle_wr_ignored", 32'(bus.wr_ready), 0);
        do_load(1, 32'h2000, 0);
        rd("fin_rd", 10, 0, 0, 20, 32'h200A, 32'h2014, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
